display_arbiter: RTL and testbench
==================================

# display_arbiter

Time-shares the single seven-segment display channel among four 4-bit sources (switches, button counter, clock counter, off/aux). Sits between the sources and the 4:1 display mux/decoder: drives the mux select and the 4-bit display value. Rotates round-robin among requesting sources with a programmable dwell time, or follows a manual select when auto mode is off.

## Interface
- DWELL_CYCLES, 50_000_000: clock cycles each grant is held in auto mode (1 s at 50 MHz); must be ≥ 2
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high
- auto_en  in  1  1 = round-robin auto mode, 0 = manual
- man_sel  in  2  source index used in manual mode
- req  in  4  per-source display request, bit i = source i
- src_val  in  16  packed source values, src_val[4i+3:4i] = source i
- hold  in  1  freeze rotation (present only with DISP_ARB_HOLD_EN)
- grant  out  4  one-hot granted source, 0 when blank
- sel  out  2  index of granted source (mux select)
- disp_val  out  4  value to decode; OFF_CODE (4'hF) when blank
- blank  out  1  display off
- switch_p  out  1  one-cycle pulse when grant changes

## Operation
- States: IDLE, DWELL, MANUAL. Rotation pointer last_idx (2 bits) persists across states.
- Reset: state IDLE, grant 0, sel 0, disp_val 4'hF, blank 1, switch_p 0, last_idx 3 (so first auto pick searches from source 0), dwell counter 0.
- IDLE (auto_en=1): if req==0 stay, blank. Else grant first requesting index in order last_idx+1, +2, +3, +4 (mod 4); load counter DWELL_CYCLES-1; go DWELL.
- DWELL: counter decrements each cycle. At 0: search next requester starting last_idx+1 with wrap; if only current requests, re-grant it and reload; if none, go IDLE (blank). A newly asserted req never preempts mid-dwell.
- Granted source dropping req mid-dwell: next cycle rotate to next requester (reload counter) or go IDLE.
- auto_en=0 from any state: go MANUAL next cycle. MANUAL: sel=man_sel; if req[man_sel], grant=onehot(man_sel), blank=0; else grant=0, blank=1, disp_val=4'hF. last_idx unchanged in MANUAL.
- auto_en 0→1: go IDLE, arbitration resumes from stored last_idx.
- disp_val tracks src_val of granted source live (registered), not sampled at grant time.
- switch_p asserts for one cycle whenever grant value changes, including to/from 0; not on a re-grant of the same source.

## Timing
- All outputs registered; req/auto_en/man_sel/src_val changes visible on outputs 1 cycle later.
- Grant held exactly DWELL_CYCLES cycles in steady multi-requester rotation.
- Counter width $clog2(DWELL_CYCLES); no overflow, reloads only on grant decision.
- reset asserted mid-dwell: next cycle all outputs at reset values, last_idx = 3.
- reset has priority over every input; auto_en=0 has priority over dwell expiry in the same cycle.

## Configuration
- DISP_ARB_HOLD_EN defined: hold port exists; in DWELL with hold=1 counter freezes and expiry is suppressed; drop of the granted req still forces rotation. No effect in IDLE/MANUAL.
- Undefined: no hold port; rotation purely dwell-driven.

## Structure
- disp_arb_pkg: state enum (IDLE, DWELL, MANUAL), NUM_SRC=4, OFF_CODE=4'hF, rr_next function (pointer + req → next index/valid).
- Sub-module dwell_timer: loadable down-counter with load, enable, zero flag; parameterised by DWELL_CYCLES.

## Test plan (DWELL_CYCLES=4)
- Reset, auto_en=1, req=4'b0000 → blank=1, disp_val=4'hF, grant=0 held indefinitely.
- req=4'b0101, src_val={4'h0,4'h7,4'h0,4'h3} → grant 0001 (disp_val 3) 4 cycles, 0100 (disp_val 7) 4 cycles, repeat; switch_p on each change.
- req=4'b0010 only → grant 0010 continuously, switch_p never reasserts after first grant.
- Granted source 0 drops req at dwell cycle 2 with req[2]=1 → grant 0100 next cycle, full 4-cycle dwell follows.
- auto_en=0, man_sel=1, req[1]=0 → blank=1, disp_val=4'hF; set req[1]=1, src_val[7:4]=4'h9 → disp_val 9 one cycle later.
- Reset asserted mid-dwell on source 2 → next cycle reset values; after release first auto grant is lowest requesting index.

Source files
------------

// File: rtl/disp_arb_pkg.sv
// -----------------------------------------------------------------------------
// disp_arb_pkg
// Shared definitions for the seven-segment display arbiter:
//   - state_t    : arbiter FSM states (IDLE, DWELL, MANUAL)
//   - NUM_SRC    : number of display sources
//   - OFF_CODE   : value driven to the decoder when the display is blank
//   - rr_next()  : round-robin search helper (pointer + request -> index/valid)
// -----------------------------------------------------------------------------
package disp_arb_pkg;

    localparam int         NUM_SRC  = 4;
    localparam logic [3:0] OFF_CODE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DWELL  = 2'd1,
        ST_MANUAL = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } rr_pick_t;

    // Search ptr+1, ptr+2, ptr+3, ptr+4 (mod 4) for the first requester.
    // ptr+4 is ptr itself, so a lone current requester is picked again.
    // The loop runs from the farthest candidate to the nearest so the
    // nearest match is the last one written and therefore wins.
    function automatic rr_pick_t rr_next(input logic [1:0] ptr,
                                         input logic [3:0] req);
        rr_pick_t   pick;
        logic [1:0] cand;
        pick = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                pick.valid = 1'b1;
                pick.idx   = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// Loadable down-counter that measures how long a grant is held.
// Ports:
//   i_clk    system clock
//   i_reset  synchronous active-high reset (count -> 0)
//   i_load   load DWELL_CYCLES-1 (has priority over i_en)
//   i_en     decrement by one; the count stops at zero
//   o_zero   count is zero (dwell expired)
// -----------------------------------------------------------------------------
module dwell_timer #(
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_zero
);

    localparam int               CNT_W    = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/display_arbiter.sv
// -----------------------------------------------------------------------------
// display_arbiter
// Time-shares one seven-segment display among four 4-bit sources. In auto
// mode it rotates round-robin among requesting sources, holding each grant
// for DWELL_CYCLES cycles; in manual mode it follows i_man_sel. All outputs
// are registered.
//
// Optional feature macro: DISP_ARB_HOLD_EN
//   defined   -> i_hold port exists; while hold=1 in DWELL the dwell counter
//                freezes and expiry is suppressed (a dropped req still rotates)
//   undefined -> no i_hold port; rotation is purely dwell-driven
//
// Ports:
//   i_clk        system clock
//   i_reset      synchronous active-high reset
//   i_auto_en    1 = round-robin auto mode, 0 = manual
//   i_man_sel    source index used in manual mode
//   i_req        per-source request, bit i = source i
//   i_src_val    packed source values, [4i+3:4i] = source i
//   i_hold       freeze rotation (DISP_ARB_HOLD_EN only)
//   o_grant      one-hot granted source, 0 when blank
//   o_sel        index of granted source (mux select)
//   o_disp_val   value to decode, OFF_CODE when blank
//   o_blank      display off
//   o_switch_p   one-cycle pulse when the grant value changes
// -----------------------------------------------------------------------------
module display_arbiter
    import disp_arb_pkg::*;
#(
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_auto_en,
    input  logic [1:0]  i_man_sel,
    input  logic [3:0]  i_req,
    input  logic [15:0] i_src_val,
`ifdef DISP_ARB_HOLD_EN
    input  logic        i_hold,
`endif
    output logic [3:0]  o_grant,
    output logic [1:0]  o_sel,
    output logic [3:0]  o_disp_val,
    output logic        o_blank,
    output logic        o_switch_p
);

    // Registered state
    state_t     r_state;
    logic [1:0] r_last_idx;
    logic [3:0] r_grant;
    logic [1:0] r_sel;
    logic [3:0] r_disp;
    logic       r_blank;
    logic       r_switch;

    // Combinational next values
    state_t     w_state_next;
    logic [1:0] w_last_next;
    logic [3:0] w_grant_next;
    logic [1:0] w_sel_next;
    logic       w_arb;
    logic       w_load;
    logic       w_en;
    logic       w_zero;
    logic       w_hold;
    rr_pick_t   w_pick;
    logic [3:0] w_src [NUM_SRC];

`ifdef DISP_ARB_HOLD_EN
    assign w_hold = i_hold;
`else
    assign w_hold = 1'b0;
`endif

    // Unpack the source values into an indexable array
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign w_src[gi] = i_src_val[4*gi +: 4];
        end
    endgenerate

    assign w_pick = rr_next(r_last_idx, i_req);

    dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_dwell_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_en    (w_en),
        .o_zero  (w_zero)
    );

    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last_idx;
        w_grant_next = r_grant;
        w_sel_next   = r_sel;
        w_arb        = 1'b0;
        w_load       = 1'b0;
        w_en         = 1'b0;

        if (!i_auto_en) begin
            // Manual mode wins over anything auto mode would do this cycle
            w_state_next = ST_MANUAL;
            w_sel_next   = i_man_sel;
            w_grant_next = i_req[i_man_sel] ? (4'b0001 << i_man_sel) : 4'b0000;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_arb = 1'b1;
                end
                ST_DWELL: begin
                    // r_last_idx always names the source granted in DWELL
                    if (!i_req[r_last_idx] || (w_zero && !w_hold)) begin
                        w_arb = 1'b1;
                    end else begin
                        w_en = !w_hold;
                    end
                end
                ST_MANUAL: begin
                    // Leave manual through IDLE; the pointer was never touched
                    w_state_next = ST_IDLE;
                    w_grant_next = 4'b0000;
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_grant_next = 4'b0000;
                end
            endcase

            if (w_arb) begin
                if (w_pick.valid) begin
                    w_state_next = ST_DWELL;
                    w_last_next  = w_pick.idx;
                    w_sel_next   = w_pick.idx;
                    w_grant_next = 4'b0001 << w_pick.idx;
                    w_load       = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                    w_grant_next = 4'b0000;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_last_idx <= 2'd3;
            r_grant    <= 4'b0000;
            r_sel      <= 2'd0;
            r_disp     <= OFF_CODE;
            r_blank    <= 1'b1;
            r_switch   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_last_idx <= w_last_next;
            r_grant    <= w_grant_next;
            r_sel      <= w_sel_next;
            r_blank    <= (w_grant_next == 4'b0000);
            // Value follows the granted source every cycle, not just at grant
            r_disp     <= (w_grant_next == 4'b0000) ? OFF_CODE : w_src[w_sel_next];
            r_switch   <= (w_grant_next != r_grant);
        end
    end

    assign o_grant    = r_grant;
    assign o_sel      = r_sel;
    assign o_disp_val = r_disp;
    assign o_blank    = r_blank;
    assign o_switch_p = r_switch;

endmodule

// File: tb/tb_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_display_arbiter
// Self-checking bench for display_arbiter with DWELL_CYCLES=4. A cycle model
// pushes the expected registered outputs into a scoreboard queue before each
// clock edge; they are popped and compared one time unit after the edge.
// Directed checks cover the documented scenarios.
// -----------------------------------------------------------------------------
module tb_display_arbiter;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        auto_en;
    logic [1:0]  man_sel;
    logic [3:0]  req;
    logic [15:0] src_val;
`ifdef DISP_ARB_HOLD_EN
    logic        hold;
`endif
    logic [3:0]  grant;
    logic [1:0]  sel;
    logic [3:0]  disp_val;
    logic        blank;
    logic        switch_p;

    always #5 clk = ~clk;

    display_arbiter #(
        .DWELL_CYCLES (D)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_auto_en  (auto_en),
        .i_man_sel  (man_sel),
        .i_req      (req),
        .i_src_val  (src_val),
`ifdef DISP_ARB_HOLD_EN
        .i_hold     (hold),
`endif
        .o_grant    (grant),
        .o_sel      (sel),
        .o_disp_val (disp_val),
        .o_blank    (blank),
        .o_switch_p (switch_p)
    );

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic [3:0] disp;
        logic       blank;
        logic       sw;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    // Model state: mode 0 idle, 1 dwell, 2 manual; m_cur = -1 when blank;
    // m_left = dwell cycles remaining including the current one
    int         m_mode;
    int         m_cur;
    int         m_last;
    int         m_left;
    logic [1:0] m_sel;
    logic [3:0] m_prev_grant;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [3:0] nib(input logic [15:0] v, input int i);
        return v[4*i +: 4];
    endfunction

    task automatic model_pick();
        bit found;
        int idx;
        found = 0;
        for (int k = 1; k <= 4; k++) begin
            idx = (m_last + k) % 4;
            if (!found && req[idx]) begin
                found  = 1;
                m_cur  = idx;
                m_last = idx;
                m_sel  = 2'(idx);
                m_left = D;
                m_mode = 1;
            end
        end
        if (!found) begin
            m_cur  = -1;
            m_mode = 0;
        end
    endtask

    task automatic model_step();
        exp_t e;
        if (reset) begin
            m_mode = 0; m_cur = -1; m_last = 3; m_left = 0; m_sel = 2'd0;
        end else if (!auto_en) begin
            m_mode = 2;
            m_sel  = man_sel;
            m_cur  = req[man_sel] ? int'(man_sel) : -1;
        end else if (m_mode == 2) begin
            m_mode = 0;
            m_cur  = -1;
        end else if (m_mode == 0) begin
            model_pick();
        end else if (!req[m_cur] || m_left == 1) begin
            model_pick();
        end else begin
            m_left--;
        end
        e.grant = (m_cur < 0) ? 4'b0000 : 4'(1 << m_cur);
        e.blank = (m_cur < 0);
        e.disp  = e.blank ? 4'hF : nib(src_val, m_cur);
        e.sel   = m_sel;
        e.sw    = reset ? 1'b0 : (e.grant != m_prev_grant);
        m_prev_grant = e.grant;
        sb.push_back(e);
    endtask

    // One clock cycle: predict, clock, then compare against the scoreboard
    task automatic step();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        $display("t=%0t rst=%b auto=%b req=%b grant=%b sel=%0d disp=%h blank=%b sw=%b",
                 $time, reset, auto_en, req, grant, sel, disp_val, blank, switch_p);
        check("sb_grant", 16'(grant),    16'(e.grant));
        check("sb_sel",   16'(sel),      16'(e.sel));
        check("sb_disp",  16'(disp_val), 16'(e.disp));
        check("sb_blank", 16'(blank),    16'(e.blank));
        check("sb_sw",    16'(switch_p), 16'(e.sw));
    endtask

    // Step until the model reports source tgt with `left` cycles remaining
    task automatic wait_grant(input string tag, input int tgt, input int left, input int max_cyc);
        bit ok;
        ok = 0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            step();
            if (m_cur == tgt && m_left == left) ok = 1;
        end
        check(tag, 16'(ok), 16'd1);
    endtask

    initial begin
        reset   = 1'b1;
        auto_en = 1'b1;
        man_sel = 2'd0;
        req     = 4'b0000;
        src_val = 16'h0000;
`ifdef DISP_ARB_HOLD_EN
        hold    = 1'b0;
`endif
        m_prev_grant = 4'b0000;

        // Reset values
        step();
        step();
        check("rst_grant", 16'(grant), 16'h0);
        check("rst_disp",  16'(disp_val), 16'hF);
        check("rst_blank", 16'(blank), 16'h1);

        // Auto mode, nobody requests: stay blank
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("idle_blank", 16'(blank), 16'h1);
        check("idle_grant", 16'(grant), 16'h0);

        // Two requesters: 0001 for D cycles then 0100 for D cycles
        req     = 4'b0101;
        src_val = {4'h0, 4'h7, 4'h0, 4'h3};
        step();
        for (int i = 0; i < 2 * D; i++) begin
            check("rr_grant", 16'(grant), (i < D) ? 16'h1 : 16'h4);
            check("rr_disp",  16'(disp_val), (i < D) ? 16'h3 : 16'h7);
            check("rr_sw",    16'(switch_p), (i == 0 || i == D) ? 16'h1 : 16'h0);
            step();
        end
        // Live tracking of the granted value
        src_val = {4'h0, 4'hA, 4'h0, 4'h5};
        for (int i = 0; i < 10; i++) step();

        // Single requester: held continuously, no further switch pulses
        req = 4'b0010;
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            check("solo_grant", 16'(grant), 16'h2);
            check("solo_sw",    16'(switch_p), 16'h0);
        end

        // Source 0 drops its request in its second dwell cycle
        req = 4'b0101;
        wait_grant("wait_src0", 0, D - 1, 20);
        req = 4'b0100;
        for (int i = 0; i < D; i++) begin
            step();
            check("drop_grant", 16'(grant), 16'h4);
        end

        // Manual mode
        auto_en = 1'b0;
        man_sel = 2'd1;
        req     = 4'b0101;
        step();
        check("man_blank", 16'(blank), 16'h1);
        check("man_disp",  16'(disp_val), 16'hF);
        req     = 4'b0111;
        src_val = {4'h0, 4'h7, 4'h9, 4'h3};
        step();
        check("man_disp9", 16'(disp_val), 16'h9);
        check("man_grant", 16'(grant), 16'h2);
        step();

        // Back to auto, then reset in the middle of a dwell on source 2
        auto_en = 1'b1;
        req     = 4'b0100;
        wait_grant("wait_src2", 2, D - 1, 20);
        reset = 1'b1;
        step();
        check("mid_rst_grant", 16'(grant), 16'h0);
        check("mid_rst_disp",  16'(disp_val), 16'hF);
        reset = 1'b0;
        req   = 4'b1010;
        step();
        check("post_rst_grant", 16'(grant), 16'h2);
        for (int i = 0; i < 6; i++) step();

        // Random traffic, model-checked every cycle
        for (int i = 0; i < 300; i++) begin
            req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) auto_en = ~auto_en;
            man_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) src_val = 16'($urandom);
            reset = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
